// File: rtl/uart_mouse_packet_parser_if.sv
// uart_mouse_packet_parser_if
//   Byte handshake between a UART receiver (master) and the mouse packet
//   parser (slave).
//   rx_data  : received byte
//   rx_avail : byte available, held by the UART until acknowledged
//   rx_error : framing error on the presented byte
//   rx_ack   : one-cycle acknowledge from the consumer
interface uart_mouse_packet_parser_if;
  logic [7:0] rx_data;
  logic       rx_avail;
  logic       rx_error;
  logic       rx_ack;

  modport master (output rx_data, output rx_avail, output rx_error, input rx_ack);
  modport slave  (input rx_data, input rx_avail, input rx_error, output rx_ack);
endinterface

// File: rtl/uart_mouse_packet_parser.sv
// uart_mouse_packet_parser
//   Parses 6-byte mouse packets (0xAA, XL, XH, YL, YH, BTN) from a UART byte
//   stream and publishes the last complete packet.
// Ports:
//   clk          : system clock
//   reset        : synchronous active-high reset
//   rx           : byte handshake (slave side), rx_ack driven here
//   mouse_x/y    : last valid coordinates {sign, low byte}
//   buttons      : last valid buttons [Middle, Right, Left]
//   packet_valid : one-cycle pulse when outputs are updated
//   frame_error  : one-cycle pulse when a packet is discarded
//   err_count    : saturating count of discarded packets
// Optional feature: define PARSER_TIMEOUT_EN to abandon a partial packet
//   after TIMEOUT_CYCLES idle cycles.
module uart_mouse_packet_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 270000
) (
  input  logic                        clk,
  input  logic                        reset,
  uart_mouse_packet_parser_if.slave   rx,
  output logic [8:0]                  mouse_x,
  output logic [8:0]                  mouse_y,
  output logic [2:0]                  buttons,
  output logic                        packet_valid,
  output logic                        frame_error,
  output logic [7:0]                  err_count
);

  typedef enum logic [2:0] {HUNT, XL, XH, YL, YH, BTN} state_t;

  localparam logic [7:0] SYNC = 8'hAA;

  state_t     state_q, state_d;
  logic       ack_q, ack_d;
  logic [7:0] xl_q, xl_d, yl_q, yl_d;
  logic       xh_q, xh_d, yh_q, yh_d;
  logic [8:0] mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
  logic [2:0] buttons_q, buttons_d;
  logic       pv_q, pv_d, fe_q, fe_d;
  logic [7:0] err_q, err_d;
  logic       consume;

  // No new byte is taken while the previous acknowledge is still high,
  // so acknowledges can never land on back-to-back cycles.
  assign consume = rx.rx_avail && !ack_q;

`ifdef PARSER_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic          timeout;

  // A consume in the same cycle wins over the timeout.
  assign timeout = (state_q != HUNT) && !consume && (tmo_q == TMO_LAST);
  assign tmo_d   = (consume || timeout || state_q == HUNT) ? '0 : tmo_q + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) tmo_q <= '0;
    else       tmo_q <= tmo_d;
  end
`else
  // Without the timeout a partial packet waits forever; this empty block
  // only marks TIMEOUT_CYCLES below 2 as a misconfiguration.
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_cycles_too_small
  end
`endif

  always_comb begin
    state_d   = state_q;
    ack_d     = consume;
    xl_d      = xl_q;
    xh_d      = xh_q;
    yl_d      = yl_q;
    yh_d      = yh_q;
    mouse_x_d = mouse_x_q;
    mouse_y_d = mouse_y_q;
    buttons_d = buttons_q;
    pv_d      = 1'b0;
    fe_d      = 1'b0;

    if (consume) begin
      if (rx.rx_error) begin
        state_d = HUNT;
        fe_d    = (state_q != HUNT);
      end else begin
        unique case (state_q)
          HUNT: if (rx.rx_data == SYNC) state_d = XL;
          XL: begin
            xl_d    = rx.rx_data;
            state_d = XH;
          end
          XH, YH: begin
            if (rx.rx_data[7:1] == 7'd0) begin
              if (state_q == XH) begin
                xh_d    = rx.rx_data[0];
                state_d = YL;
              end else begin
                yh_d    = rx.rx_data[0];
                state_d = BTN;
              end
            end else begin
              // An invalid byte that happens to be the sync byte starts
              // the next packet immediately.
              fe_d    = 1'b1;
              state_d = (rx.rx_data == SYNC) ? XL : HUNT;
            end
          end
          YL: begin
            yl_d    = rx.rx_data;
            state_d = YH;
          end
          BTN: begin
            if (rx.rx_data[7:3] == 5'd0) begin
              pv_d      = 1'b1;
              mouse_x_d = {xh_q, xl_q};
              mouse_y_d = {yh_q, yl_q};
              buttons_d = rx.rx_data[2:0];
              state_d   = HUNT;
            end else begin
              fe_d    = 1'b1;
              state_d = (rx.rx_data == SYNC) ? XL : HUNT;
            end
          end
          default: state_d = HUNT;
        endcase
      end
    end
`ifdef PARSER_TIMEOUT_EN
    else if (timeout) begin
      fe_d    = 1'b1;
      state_d = HUNT;
    end
`endif

    err_d = (fe_d && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= HUNT;
      ack_q     <= 1'b0;
      xl_q      <= '0;
      xh_q      <= 1'b0;
      yl_q      <= '0;
      yh_q      <= 1'b0;
      mouse_x_q <= '0;
      mouse_y_q <= '0;
      buttons_q <= '0;
      pv_q      <= 1'b0;
      fe_q      <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      xl_q      <= xl_d;
      xh_q      <= xh_d;
      yl_q      <= yl_d;
      yh_q      <= yh_d;
      mouse_x_q <= mouse_x_d;
      mouse_y_q <= mouse_y_d;
      buttons_q <= buttons_d;
      pv_q      <= pv_d;
      fe_q      <= fe_d;
      err_q     <= err_d;
    end
  end

  assign rx.rx_ack    = ack_q;
  assign mouse_x      = mouse_x_q;
  assign mouse_y      = mouse_y_q;
  assign buttons      = buttons_q;
  assign packet_valid = pv_q;
  assign frame_error  = fe_q;
  assign err_count    = err_q;

endmodule

// File: tb/tb_uart_mouse_packet_parser.sv
// tb_uart_mouse_packet_parser
//   Drives byte streams through the UART handshake and compares every
//   output on every cycle against a packet-level model of the parser.
//   Directed sequences pin the model with literal expectations, then a
//   randomized mix of good, corrupted, error and reset traffic follows.
module tb_uart_mouse_packet_parser;

  localparam int TMO = 100;

  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [8:0] mouse_x, mouse_y;
  logic [2:0] buttons;
  logic       packet_valid, frame_error;
  logic [7:0] err_count;

  uart_mouse_packet_parser_if rx_if ();

  uart_mouse_packet_parser #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (rst),
    .rx           (rx_if),
    .mouse_x      (mouse_x),
    .mouse_y      (mouse_y),
    .buttons      (buttons),
    .packet_valid (packet_valid),
    .frame_error  (frame_error),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int pv_cnt = 0;
  int fe_cnt = 0;
  int acks_seen = 0;
  int bytes_sent = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + per-cycle compare ----------------
  // The model tracks how many bytes of the current packet have been
  // collected (0 = waiting for the sync byte) and the collected bytes.
  int         m_n = 0;
  int         m_idle = 0;
  logic [7:0] m_pkt [1:5];
  logic       exp_ack = 1'b0, exp_pv = 1'b0, exp_fe = 1'b0;
  logic [8:0] exp_x = '0, exp_y = '0;
  logic [2:0] exp_b = '0;
  logic [7:0] exp_err = '0;
  bit         seen_rst = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (seen_rst) begin
        chk("rx_ack", rx_if.rx_ack, exp_ack);
        chk("packet_valid", packet_valid, exp_pv);
        chk("frame_error", frame_error, exp_fe);
        chk("mouse_x", mouse_x, exp_x);
        chk("mouse_y", mouse_y, exp_y);
        chk("buttons", buttons, exp_b);
        chk("err_count", err_count, exp_err);
        if (packet_valid === 1'b1) pv_cnt++;
        if (frame_error === 1'b1) fe_cnt++;
        if (rx_if.rx_ack === 1'b1) acks_seen++;
      end
      if (rst) begin
        m_n = 0; m_idle = 0;
        exp_ack = 0; exp_pv = 0; exp_fe = 0;
        exp_x = '0; exp_y = '0; exp_b = '0; exp_err = '0;
        seen_rst = 1'b1;
      end else if (seen_rst) begin
        logic       cons;
        logic [7:0] b;
        bit         ok;
        cons = rx_if.rx_avail && !exp_ack;
        b = rx_if.rx_data;
        exp_ack = cons; exp_pv = 0; exp_fe = 0;
        if (cons) begin
          m_idle = 0;
          if (rx_if.rx_error) begin
            if (m_n != 0) exp_fe = 1;
            m_n = 0;
          end else if (m_n == 0) begin
            if (b == 8'hAA) m_n = 1;
          end else begin
            if (m_n == 2 || m_n == 4) ok = (b <= 8'd1);
            else if (m_n == 5)        ok = (b < 8'd8);
            else                      ok = 1;
            if (!ok) begin
              exp_fe = 1;
              m_n = (b == 8'hAA) ? 1 : 0;
            end else begin
              m_pkt[m_n] = b;
              if (m_n == 5) begin
                exp_pv = 1;
                exp_x = {m_pkt[2][0], m_pkt[1]};
                exp_y = {m_pkt[4][0], m_pkt[3]};
                exp_b = b[2:0];
                m_n = 0;
              end else begin
                m_n++;
              end
            end
          end
        end
`ifdef PARSER_TIMEOUT_EN
        else if (m_n != 0) begin
          m_idle++;
          if (m_idle == TMO) begin
            exp_fe = 1;
            m_n = 0;
          end
        end
`endif
        if (m_n == 0) m_idle = 0;
        if (exp_fe && exp_err != 8'hFF) exp_err++;
        if (exp_pv) $display("packet  x=%03h y=%03h buttons=%03b", exp_x, exp_y, exp_b);
        if (exp_fe) $display("discard err_count=%0d", exp_err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  task automatic present(input logic [7:0] b, input logic e);
    rx_if.rx_data  = b;
    rx_if.rx_error = e;
    rx_if.rx_avail = 1'b1;
  endtask

  task automatic wait_ack();
    bit got = 1'b0;
    for (int k = 0; k < 12 && !got; k++) begin
      @(posedge clk); #1;
      got = (rx_if.rx_ack === 1'b1);
    end
    n_vec++;
    if (!got) begin
      n_err++;
      $display("FAIL ack_wait: got no rx_ack required one within 12 cycles at %0t", $time);
    end
    rx_if.rx_avail = 1'b0;
    bytes_sent++;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic e);
    present(b, e);
    wait_ack();
  endtask

  task automatic send_seq(input bq_t q, input bit gaps);
    foreach (q[i]) begin
      send_byte(q[i], 1'b0);
      if (gaps && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  task automatic gen_valid(output bq_t q);
    q = {};
    q.push_back(8'hAA);
    q.push_back(8'($urandom_range(0, 255)));
    q.push_back(8'($urandom_range(0, 1)));
    q.push_back(8'($urandom_range(0, 255)));
    q.push_back(8'($urandom_range(0, 1)));
    q.push_back(8'($urandom_range(0, 7)));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bq_t seq;
    int  pv0, fe0;
    rx_if.rx_data = '0; rx_if.rx_avail = 1'b0; rx_if.rx_error = 1'b0;
    idle(3);
    rst = 1'b0;

    // Reset state
    chk("rst_mouse_x", mouse_x, 9'h000);
    chk("rst_err_count", err_count, 8'h00);
    chk("rst_rx_ack", rx_if.rx_ack, 1'b0);

    // Byte pending across reset, then a basic packet
    pv0 = pv_cnt;
    present(8'hAA, 1'b0);
    do_reset(2);
    wait_ack();
    seq = '{8'h05, 8'h00, 8'hFB, 8'h01, 8'h03};
    send_seq(seq, 1'b0);
    idle(2);
    chk("p1_pv_count", pv_cnt - pv0, 1);
    chk("p1_mouse_x", mouse_x, 9'h005);
    chk("p1_mouse_y", mouse_y, 9'h1FB);
    chk("p1_buttons", buttons, 3'b011);
    chk("p1_err_count", err_count, 8'd0);

    // Leading junk dropped, 0xAA accepted as data in XL/YL
    do_reset(2);
    pv0 = pv_cnt; fe0 = fe_cnt;
    seq = '{8'h12, 8'hAA, 8'hAA, 8'h00, 8'hAA, 8'h00, 8'h04};
    send_seq(seq, 1'b1);
    idle(2);
    chk("p2_pv_count", pv_cnt - pv0, 1);
    chk("p2_fe_count", fe_cnt - fe0, 0);
    chk("p2_mouse_x", mouse_x, 9'h0AA);
    chk("p2_mouse_y", mouse_y, 9'h0AA);
    chk("p2_buttons", buttons, 3'b100);

    // Invalid XH equal to sync resynchronises
    do_reset(2);
    pv0 = pv_cnt; fe0 = fe_cnt;
    seq = '{8'hAA, 8'h10, 8'hAA, 8'h20, 8'h00, 8'h30, 8'h00, 8'h01};
    send_seq(seq, 1'b0);
    idle(2);
    chk("p3_pv_count", pv_cnt - pv0, 1);
    chk("p3_fe_count", fe_cnt - fe0, 1);
    chk("p3_mouse_x", mouse_x, 9'h020);
    chk("p3_mouse_y", mouse_y, 9'h030);
    chk("p3_buttons", buttons, 3'b001);
    chk("p3_err_count", err_count, 8'd1);

    // Reset mid-packet discards silently
    do_reset(2);
    pv0 = pv_cnt; fe0 = fe_cnt;
    seq = '{8'hAA, 8'h01, 8'h00};
    send_seq(seq, 1'b0);
    do_reset(2);
    seq = '{8'hAA, 8'h02, 8'h00, 8'h02, 8'h00, 8'h00};
    send_seq(seq, 1'b0);
    idle(2);
    chk("p4_fe_count", fe_cnt - fe0, 0);
    chk("p4_pv_count", pv_cnt - pv0, 1);
    chk("p4_mouse_x", mouse_x, 9'h002);
    chk("p4_mouse_y", mouse_y, 9'h002);

    // Framing error: in a packet it discards, in HUNT it is silent
    do_reset(2);
    send_byte(8'hAA, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    idle(2);
    chk("p5_err_count", err_count, 8'd1);

    // Idle partial packet (times out only when the feature is built in)
    do_reset(2);
    seq = '{8'hAA, 8'h07};
    send_seq(seq, 1'b0);
    idle(TMO + 10);
`ifdef PARSER_TIMEOUT_EN
    chk("p6_err_after_idle", err_count, 8'd1);
`else
    chk("p6_err_after_idle", err_count, 8'd0);
`endif
    seq = '{8'hAA, 8'h01, 8'h00, 8'h01, 8'h00, 8'h07};
    send_seq(seq, 1'b0);
    idle(2);
    chk("p6_buttons", buttons, 3'b111);
    chk("p6_mouse_x", mouse_x, 9'h001);
    chk("p6_err_count", err_count, 8'd1);

    // Error counter saturation, back-to-back bytes
    do_reset(2);
    pv0 = pv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 300; i++) begin
      seq = '{8'hAA, 8'h00, 8'h02};
      send_seq(seq, 1'b0);
    end
    idle(2);
    chk("p7_err_count", err_count, 8'hFF);
    chk("p7_fe_count", fe_cnt - fe0, 300);
    chk("p7_pv_count", pv_cnt - pv0, 0);
    chk("p7_mouse_x", mouse_x, 9'h000);

    // Randomized traffic
    do_reset(2);
    for (int it = 0; it < 300; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        gen_valid(seq);
        send_seq(seq, 1'b1);
      end else if (r == 6) begin
        gen_valid(seq);
        seq[$urandom_range(1, 5)] = 8'($urandom_range(0, 255));
        send_seq(seq, 1'b1);
      end else if (r == 7) begin
        repeat ($urandom_range(1, 4))
          send_byte(($urandom_range(0, 1) == 1) ? 8'hAA : 8'($urandom_range(0, 255)), 1'b0);
      end else if (r == 8) begin
        send_byte(8'($urandom_range(0, 255)), 1'b1);
      end else begin
        do_reset($urandom_range(1, 3));
      end
    end
    idle(3);
    chk("ack_per_byte", acks_seen, bytes_sent);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
